fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined ARM CPU. It holds the PC, presents it to instruction memory, and registers the fetched word plus its PC into IF/ID. The 11-bit opcode it produces drives `CPU_control` in ID. It takes back the branch controls resolved in ID (`brTaken`, `uncondBr`, `branchReg`) to redirect the PC.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  64  current PC, equal to `pc`, driven combinationally.
- `imem_rdata`  in  32  instruction word at `imem_addr`, valid the same cycle.
- `imem_valid`  in  1  `imem_rdata` is valid this cycle.
- `stall`  in  1  hazard-unit stall; hold the PC and IF/ID.
- `brTaken`  in  1  ID instruction is a branch class (from control).
- `uncondBr`  in  1  unconditional branch (B, BL, BR).
- `branchReg`  in  1  target comes from a register (BR).
- `cond_met`  in  1  branch condition true: flags for B.cond, zero for CBZ.
- `reg_target`  in  64  register value for BR.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_instr`  out  32  IF/ID instruction.
- `id_opcode`  out  11  `id_instr[31:21]`, combinational; feeds the control decoder.
- `id_pc`  out  64  PC of the IF/ID instruction.
- `id_pc_plus4`  out  64  `id_pc + 4`, combinational; BL link value.
- `fetch_count`  out  CNT_W  instructions accepted into IF/ID.
- `bubble_count`  out  CNT_W  bubbles inserted into IF/ID.

## Operation
- Taken branch: `redirect = id_valid & brTaken & (uncondBr | cond_met) & ~stall`. Branch inputs are ignored when `id_valid` is 0.
- Branch target:
  - `branchReg` = 1: `reg_target`.
  - Otherwise `uncondBr` = 1: `id_pc + (sext(id_instr[25:0]) << 2)`.
  - Otherwise: `id_pc + (sext(id_instr[23:5]) << 2)`.
  - All arithmetic is 64-bit and wraps modulo 2^64.
- Per-cycle priority, evaluated on each edge:
  1. `stall`: `pc`, IF/ID and both counters hold. `imem_valid` is ignored.
  2. `redirect`: `pc` ← target. IF/ID ← bubble (`id_valid` 0, `id_instr` 0, `id_pc` 0). The word fetched this cycle is discarded. `bubble_count` +1.
  3. `imem_valid`: `pc` ← `pc + 4`. IF/ID ← {1, `imem_rdata`, `pc`}. `fetch_count` +1.
  4. Otherwise (memory not ready): `pc` holds, IF/ID ← bubble, `bubble_count` +1.
- Fetch state machine, one state register:
  - BOOT: the first edge after reset release moves to RUN unconditionally. No fetch is accepted and no counter changes on that edge.
  - RUN: applies the priority rules above.
- Counters saturate at all-ones; they do not wrap.
- No branch delay slot. Every taken branch costs exactly one bubble.
- Non-taken branches (B.cond/CBZ with `cond_met` = 0) behave as normal instructions; no bubble.

## Timing
- Reset (asynchronous assert, any time, including mid-stall or mid-redirect):
  - `pc` = RESET_PC, state = BOOT.
  - `id_valid` = 0, `id_instr` = 0, `id_pc` = 0.
  - `fetch_count` = 0, `bubble_count` = 0.
  - Consequently `imem_addr` = RESET_PC, `id_opcode` = 0, `id_pc_plus4` = 4.
- Reset deassert is taken synchronously. First edge → BOOT→RUN. Second edge → first instruction (at RESET_PC) enters IF/ID.
- IF→ID latency: 1 cycle. A word presented with `imem_valid` on edge N appears on `id_*` after edge N.
- Branch redirect: a branch in ID at edge N loads the target into `pc` at N. The target instruction reaches ID at edge N+1, so one bubble is visible in ID during cycle N..N+1.
- Branch held under stall: a branch in ID while `stall` = 1 is resolved on the first non-stall edge.
- Simultaneous `redirect` and `imem_valid`: redirect wins; the fetched word is dropped and not counted.

## Test plan
- Reset then `imem_valid` held at 1 with RESET_PC = 0:
  - After edge 1: `id_valid` = 0.
  - After edge 2: `id_pc` = 0, `id_valid` = 1.
  - After edge 3: `id_pc` = 4, `fetch_count` = 2.
- B forward with `id_instr` = 32'h14000004 at `id_pc` = 0x10 (`brTaken` = `uncondBr` = 1):
  - Next edge: `pc` = 0x20, `id_valid` = 0, `bubble_count` +1.
  - Following edge: `id_pc` = 0x20.
- CBZ with imm19 = −2 at `id_pc` = 0x40:
  - `cond_met` = 1 → `pc` = 0x38.
  - `cond_met` = 0 → `pc` advances to `pc + 4` with no bubble.
- BR with `reg_target` = 0x1000 and `stall` = 1 for 2 cycles:
  - `pc`, IF/ID and counters frozen during the stall.
  - First non-stall edge → `pc` = 0x1000.
- `imem_valid` = 0 for 3 cycles: `pc` holds, 3 bubbles enter IF/ID, `bubble_count` = 3, `fetch_count` unchanged.
- Async `reset` asserted mid-redirect: outputs return to reset values immediately, before any clock edge. Any pending branch is lost.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage and IF/ID pipeline register
//
// Holds the PC and presents it to instruction memory. Each fetched word is
// registered into IF/ID together with its PC. Branches resolved in ID
// redirect the PC, and every taken branch places one bubble in IF/ID.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   imem_addr           current PC (combinational)
//   imem_rdata/valid    instruction word at imem_addr and its valid flag
//   stall               hold PC, IF/ID and counters
//   brTaken, uncondBr,
//   branchReg, cond_met,
//   reg_target          branch controls and register target from ID
//   id_valid/instr/pc   IF/ID register contents
//   id_opcode           id_instr[31:21] for the control decoder
//   id_pc_plus4         id_pc + 4, the BL link value
//   fetch_count         saturating count of instructions accepted into IF/ID
//   bubble_count        saturating count of bubbles inserted into IF/ID
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [63:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  input  logic             stall,
  input  logic             brTaken,
  input  logic             uncondBr,
  input  logic             branchReg,
  input  logic             cond_met,
  input  logic [63:0]      reg_target,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [10:0]      id_opcode,
  output logic [63:0]      id_pc,
  output logic [63:0]      id_pc_plus4,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]  state;
  logic [63:0] pc;
  logic        redirect;
  logic [63:0] uncondOffset;
  logic [63:0] condOffset;
  logic [63:0] target;

  assign imem_addr   = pc;
  assign id_opcode   = id_instr[31:21];
  assign id_pc_plus4 = id_pc + 64'd4;

  // Branch inputs only mean something while ID holds a real instruction.
  assign redirect = id_valid & brTaken & (uncondBr | cond_met) & ~stall;

  // imm26 for B/BL, imm19 for B.cond/CBZ; both are word offsets.
  assign uncondOffset = {{36{id_instr[25]}}, id_instr[25:0], 2'b00};
  assign condOffset   = {{43{id_instr[23]}}, id_instr[23:5], 2'b00};

  always_comb begin
    target = id_pc + condOffset;
    if (branchReg) begin
      target = reg_target;
    end else if (uncondBr) begin
      target = id_pc + uncondOffset;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      id_valid     <= 1'b0;
      id_instr     <= 32'd0;
      id_pc        <= 64'd0;
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        default: begin
          if (!stall) begin
            if (redirect || !imem_valid) begin
              // A redirect drops the word fetched this cycle without counting it.
              if (redirect) begin
                pc <= target;
              end
              id_valid <= 1'b0;
              id_instr <= 32'd0;
              id_pc    <= 64'd0;
              if (bubble_count != CNT_MAX) begin
                bubble_count <= bubble_count + CNT_ONE;
              end
            end else begin
              pc       <= pc + 64'd4;
              id_valid <= 1'b1;
              id_instr <= imem_rdata;
              id_pc    <= pc;
              if (fetch_count != CNT_MAX) begin
                fetch_count <= fetch_count + CNT_ONE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int unsigned CW = 4;
  localparam int CNT_SAT = (1 << CW) - 1;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_valid;
  logic          stall;
  logic          brTaken;
  logic          uncondBr;
  logic          branchReg;
  logic          cond_met;
  logic [63:0]   reg_target;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [10:0]   id_opcode;
  logic [63:0]   id_pc;
  logic [63:0]   id_pc_plus4;
  logic [CW-1:0] fetch_count;
  logic [CW-1:0] bubble_count;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  logic [63:0] mPc;
  logic [63:0] mIdPc;
  logic        mValid;
  logic [31:0] mInstr;
  int          mFetch;
  int          mBubble;
  bit          mBooted;

  fetch_unit #(.RESET_PC(64'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .brTaken(brTaken), .uncondBr(uncondBr), .branchReg(branchReg),
    .cond_met(cond_met), .reg_target(reg_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_opcode(id_opcode),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 64'h0; mIdPc = 64'h0; mValid = 1'b0; mInstr = 32'h0;
    mFetch = 0; mBubble = 0; mBooted = 1'b0;
  endtask

  function automatic logic [63:0] branchTarget();
    longint off;
    if (branchReg) return reg_target;
    if (uncondBr) off = longint'($signed(mInstr[25:0])) * 4;
    else          off = longint'($signed(mInstr[23:5])) * 4;
    return mIdPc + 64'(off);
  endfunction

  task automatic bubbleIn();
    mValid = 1'b0; mInstr = 32'h0; mIdPc = 64'h0;
    if (mBubble < CNT_SAT) mBubble++;
  endtask

  // One clock edge of the specified behaviour, using the inputs as driven now.
  task automatic modelEdge();
    if (!mBooted) begin
      mBooted = 1'b1;
    end else if (!stall) begin
      if (mValid && brTaken && (uncondBr || cond_met)) begin
        mPc = branchTarget();
        bubbleIn();
      end else if (imem_valid) begin
        mValid = 1'b1; mInstr = imem_rdata; mIdPc = mPc;
        mPc = mPc + 64'd4;
        if (mFetch < CNT_SAT) mFetch++;
      end else begin
        bubbleIn();
      end
    end
  endtask

  task automatic checkAll();
    check("imem_addr", imem_addr, mPc);
    check("id_valid", 64'(id_valid), 64'(mValid));
    check("id_instr", 64'(id_instr), 64'(mInstr));
    check("id_opcode", 64'(id_opcode), 64'(mInstr >> 21));
    check("id_pc", id_pc, mIdPc);
    check("id_pc_plus4", id_pc_plus4, mIdPc + 64'd4);
    check("fetch_count", 64'(fetch_count), 64'(mFetch));
    check("bubble_count", 64'(bubble_count), 64'(mBubble));
  endtask

  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic clearBranch();
    brTaken = 1'b0; uncondBr = 1'b0; branchReg = 1'b0; cond_met = 1'b0;
    stall = 1'b0; imem_valid = 1'b1; imem_rdata = NOP;
  endtask

  task automatic fetchTo(input logic [63:0] addr);
    clearBranch();
    for (int i = 0; i < 64 && mPc != addr; i++) step();
    check("fetch_to", imem_addr, addr);
  endtask

  initial begin
    reset = 1'b0;
    reg_target = 64'h0;
    clearBranch();
    modelReset();

    // Reset state
    #3;
    checkAll();
    check("rst_addr", imem_addr, 64'h0);
    check("rst_plus4", id_pc_plus4, 64'h4);
    check("rst_opcode", 64'(id_opcode), 64'h0);
    @(posedge clk); #1;
    checkAll();
    reset = 1'b1;

    // Boot then straight-line fetch
    step(); check("boot_e1_valid", 64'(id_valid), 64'h0);
    step(); check("boot_e2_pc", id_pc, 64'h0); check("boot_e2_valid", 64'(id_valid), 64'h1);
    step(); check("boot_e3_pc", id_pc, 64'h4); check("boot_e3_fetch", 64'(fetch_count), 64'h2);

    // B forward: 0x14000004 at 0x10 -> 0x20
    fetchTo(64'h10);
    imem_rdata = 32'h14000004;
    step(); check("b_in_id", id_pc, 64'h10);
    imem_rdata = NOP; brTaken = 1'b1; uncondBr = 1'b1;
    step();
    check("b_pc", imem_addr, 64'h20);
    check("b_bubble_valid", 64'(id_valid), 64'h0);
    check("b_bubble_cnt", 64'(bubble_count), 64'h1);
    clearBranch();
    step(); check("b_target_id", id_pc, 64'h20);

    // CBZ imm19 = -2 at 0x40, taken
    fetchTo(64'h40);
    imem_rdata = 32'hB4FFFFC0;
    step();
    imem_rdata = NOP; brTaken = 1'b1; cond_met = 1'b1;
    step();
    check("cbz_taken_pc", imem_addr, 64'h38);
    check("cbz_taken_bubbles", 64'(bubble_count), 64'h2);

    // Same CBZ, not taken
    fetchTo(64'h40);
    imem_rdata = 32'hB4FFFFC0;
    step();
    imem_rdata = NOP; brTaken = 1'b1; cond_met = 1'b0;
    step();
    check("cbz_nt_pc", imem_addr, 64'h48);
    check("cbz_nt_valid", 64'(id_valid), 64'h1);
    check("cbz_nt_bubbles", 64'(bubble_count), 64'h2);
    clearBranch();

    // BR X1 held under a two-cycle stall
    imem_rdata = 32'hD61F0020;
    step();
    imem_rdata = NOP; brTaken = 1'b1; uncondBr = 1'b1; branchReg = 1'b1;
    reg_target = 64'h1000; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("br_stall_pc", imem_addr, 64'h4C);
      check("br_stall_id", id_pc, 64'h48);
      check("br_stall_bubbles", 64'(bubble_count), 64'h2);
    end
    stall = 1'b0;
    step();
    check("br_pc", imem_addr, 64'h1000);
    check("br_bubbles", 64'(bubble_count), 64'h3);
    clearBranch();

    // Memory not ready for three cycles
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("nrdy_pc", imem_addr, 64'h1000);
    check("nrdy_bubbles", 64'(bubble_count), 64'h6);
    check("nrdy_valid", 64'(id_valid), 64'h0);
    imem_valid = 1'b1;

    // Randomized traffic; counters saturate along the way
    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom_range(0, 3) == 0);
      imem_valid = ($urandom_range(0, 3) != 0);
      imem_rdata = $urandom;
      brTaken    = ($urandom_range(0, 2) == 0);
      uncondBr   = $urandom_range(0, 1) == 1;
      branchReg  = ($urandom_range(0, 3) == 0);
      cond_met   = $urandom_range(0, 1) == 1;
      reg_target = {$urandom, $urandom};
      step();
    end
    check("sat_fetch", 64'(fetch_count), 64'(CNT_SAT));
    check("sat_bubble", 64'(bubble_count), 64'(CNT_SAT));

    // Asynchronous reset in the middle of a redirect
    clearBranch();
    imem_rdata = 32'h14000010;
    step();
    check("ar_branch_in_id", 64'(id_valid), 64'h1);
    brTaken = 1'b1; uncondBr = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    check("ar_addr", imem_addr, 64'h0);
    check("ar_plus4", id_pc_plus4, 64'h4);
    @(posedge clk); #1;
    checkAll();
    reset = 1'b1;
    clearBranch();
    step(); check("ar_boot_valid", 64'(id_valid), 64'h0);
    step(); check("ar_first_pc", id_pc, 64'h0); check("ar_first_valid", 64'(id_valid), 64'h1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
